// File: rtl/bg_scroll_renderer.sv
// Full-screen background renderer: stretches an indexed image over the active area
// with per-frame horizontal scroll, an external 1-cycle ROM and a writable palette.
module bg_scroll_renderer #(
  parameter int unsigned IMG_W    = 512,
  parameter int unsigned IMG_H    = 480,
  parameter int unsigned SCREEN_W = 640,
  parameter int unsigned SCREEN_H = 480,
  parameter int unsigned BPP      = 4,
  parameter int unsigned ADDR_W   = 18
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic [9:0]        scroll_x,
  input  logic              pal_we,
  input  logic [BPP-1:0]    pal_waddr,
  input  logic [11:0]       pal_wdata,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [BPP-1:0]    rom_q,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue
);

  localparam logic [11:0]       ImgW  = 12'(IMG_W);
  localparam logic [11:0]       ImgH  = 12'(IMG_H);
  localparam logic [11:0]       ScrW  = 12'(SCREEN_W);
  localparam logic [11:0]       ScrH  = 12'(SCREEN_H);
  localparam logic [ADDR_W-1:0] RowSz = ADDR_W'(IMG_W);

  logic [11:0]       dx, dy;
  logic [11:0]       sx_q, sx_d, err_x_q, err_x_d, err_x_sum;
  logic [11:0]       err_y_q, err_y_d, err_y_sum;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [11:0]       scroll_q, scroll_d;
  logic [11:0]       col_sum, col;
  logic              blank_d1_q;
  logic [11:0]       rgb_q;
  logic [11:0]       pal_q [2**BPP];

  assign dx        = {2'b00, DrawX};
  assign dy        = {2'b00, DrawY};
  assign err_x_sum = err_x_q + ImgW;
  assign err_y_sum = err_y_q + ImgH;

  always_comb begin
    sx_d    = sx_q;
    err_x_d = err_x_q;
    if (dx >= ScrW) begin
      sx_d    = '0;
      err_x_d = '0;
    end else if (err_x_sum >= ScrW) begin
      sx_d    = sx_q + 12'd1;
      err_x_d = err_x_sum - ScrW;
    end else begin
      err_x_d = err_x_sum;
    end
  end

  // The last active line does not step, so the row base never reaches IMG_H rows.
  always_comb begin
    err_y_d = err_y_q;
    base_d  = base_q;
    if (dy >= ScrH) begin
      err_y_d = '0;
      base_d  = '0;
    end else if (dx == ScrW && dy != ScrH - 12'd1) begin
      if (err_y_sum >= ScrH) begin
        err_y_d = err_y_sum - ScrH;
        base_d  = base_q + RowSz;
      end else begin
        err_y_d = err_y_sum;
      end
    end
  end

  always_comb begin
    scroll_d = scroll_q;
    if (dy >= ScrH && {2'b00, scroll_x} < ImgW) begin
      scroll_d = {2'b00, scroll_x};
    end
  end

  // sx <= IMG_W and scroll < IMG_W, so one conditional subtract completes the wrap.
  assign col_sum     = sx_q + scroll_q;
  assign col         = (col_sum >= ImgW) ? col_sum - ImgW : col_sum;
  assign rom_address = base_q + ADDR_W'(col);

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      sx_q     <= '0;
      err_x_q  <= '0;
      err_y_q  <= '0;
      base_q   <= '0;
      scroll_q <= '0;
    end else begin
      sx_q     <= sx_d;
      err_x_q  <= err_x_d;
      err_y_q  <= err_y_d;
      base_q   <= base_d;
      scroll_q <= scroll_d;
    end
  end

  // Palette read and write share an edge, so a same-index read sees the old entry.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      for (int i = 0; i < 2**BPP; i++) begin
        pal_q[i] <= '0;
      end
      blank_d1_q <= 1'b0;
      rgb_q      <= '0;
    end else begin
      if (pal_we) begin
        pal_q[pal_waddr] <= pal_wdata;
      end
      blank_d1_q <= blank;
      rgb_q      <= blank_d1_q ? pal_q[rom_q] : 12'h000;
    end
  end

  assign red   = rgb_q[11:8];
  assign green = rgb_q[7:4];
  assign blue  = rgb_q[3:0];

endmodule

// File: tb/tb_bg_scroll_renderer.sv
// Directed bench for bg_scroll_renderer: address mapping at two image sizes, scroll
// latching/wrap, palette pipeline latency, same-cycle write and reset clearing.
module tb_bg_scroll_renderer;

  logic        vga_clk = 1'b0;
  logic        reset;
  logic [9:0]  DrawX, DrawY, scroll_x;
  logic        blank, pal_we;
  logic [3:0]  pal_waddr, rom_q;
  logic [11:0] pal_wdata;
  logic [17:0] addr_big;
  logic [16:0] addr_small;
  logic [3:0]  red, green, blue;
  logic [3:0]  red_s, green_s, blue_s;

  int checks = 0;
  int failures = 0;

  always #5 vga_clk = ~vga_clk;

  bg_scroll_renderer dut (
    .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .scroll_x(scroll_x), .pal_we(pal_we), .pal_waddr(pal_waddr), .pal_wdata(pal_wdata),
    .rom_address(addr_big), .rom_q(rom_q), .red(red), .green(green), .blue(blue)
  );

  bg_scroll_renderer #(
    .IMG_W(320), .IMG_H(240), .SCREEN_W(640), .SCREEN_H(480), .BPP(4), .ADDR_W(17)
  ) dut_small (
    .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .scroll_x(scroll_x), .pal_we(pal_we), .pal_waddr(pal_waddr), .pal_wdata(pal_wdata),
    .rom_address(addr_small), .rom_q(rom_q), .red(red_s), .green(green_s), .blue(blue_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int x, input int y);
    DrawX = 10'(x);
    DrawY = 10'(y);
    #1;
  endtask

  task automatic tick();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic run_line(input int y, input int x0, input int x1);
    for (int x = x0; x <= x1; x++) begin
      drive(x, y);
      tick();
    end
  endtask

  task automatic hblank_lines(input int y0, input int y1);
    for (int y = y0; y <= y1; y++) begin
      drive(640, y);
      tick();
    end
  endtask

  task automatic vblank(input int n);
    for (int i = 0; i < n; i++) begin
      drive(640, 480 + (i % 4));
      tick();
    end
  endtask

  initial begin
    reset = 1'b1; blank = 1'b0; pal_we = 1'b0; pal_waddr = '0; pal_wdata = '0;
    rom_q = '0; scroll_x = '0;
    drive(0, 0);
    tick();
    tick();
    check("reset_rgb", {20'd0, red, green, blue}, 32'h0);
    check("reset_addr", {14'd0, addr_big}, 32'd0);
    reset = 1'b0;

    // Frame 1, scroll 0
    drive(0, 0);
    check("small_x0", {15'd0, addr_small}, 32'd0);
    tick();
    drive(1, 0); check("small_x1", {15'd0, addr_small}, 32'd0); tick();
    drive(2, 0); check("small_x2", {15'd0, addr_small}, 32'd1); tick();
    drive(3, 0); check("small_x3", {15'd0, addr_small}, 32'd1); tick();
    run_line(0, 4, 4);
    drive(5, 0); check("big_x5", {14'd0, addr_big}, 32'd4); tick();
    run_line(0, 6, 638);
    drive(639, 0);
    check("big_x639", {14'd0, addr_big}, 32'd511);
    check("small_x639", {15'd0, addr_small}, 32'd319);
    tick();
    hblank_lines(0, 1);
    drive(0, 2);
    check("small_y2", {15'd0, addr_small}, 32'd320);
    check("big_y2", {14'd0, addr_big}, 32'd1024);
    tick();
    hblank_lines(2, 478);
    run_line(479, 0, 638);
    drive(639, 479);
    check("big_last", {14'd0, addr_big}, 32'd245759);
    check("small_last", {15'd0, addr_small}, 32'd76799);
    tick();
    drive(640, 479);
    check("big_hblank_range", {31'd0, addr_big < 18'd245760}, 32'd1);
    check("small_hblank_range", {31'd0, addr_small < 17'd76800}, 32'd1);
    tick();

    // Frame 2: scroll 500 loads in the big image, is ignored by the 320-wide one
    scroll_x = 10'd500;
    vblank(3);
    run_line(0, 0, 19);
    drive(20, 0);
    check("big_scroll_wrap", {14'd0, addr_big}, 32'd4);
    check("small_scroll_ignored", {15'd0, addr_small}, 32'd10);
    tick();
    scroll_x = 10'd100;
    run_line(0, 21, 24);
    drive(25, 0);
    check("big_midframe_hold", {14'd0, addr_big}, 32'd8);
    check("small_midframe_hold", {15'd0, addr_small}, 32'd12);
    tick();
    run_line(0, 26, 639);
    hblank_lines(0, 0);
    vblank(2);
    scroll_x = 10'd600;
    vblank(2);

    // Frame 3: scroll 100 latched, 600 rejected by both
    drive(0, 0);
    check("big_scroll100_x0", {14'd0, addr_big}, 32'd100);
    tick();
    run_line(0, 1, 4);
    drive(5, 0);
    check("big_scroll100_x5", {14'd0, addr_big}, 32'd104);
    check("small_scroll100_x5", {15'd0, addr_small}, 32'd102);
    tick();

    // Palette pipeline
    pal_we = 1'b1; pal_waddr = 4'd3; pal_wdata = 12'hF80;
    tick();
    pal_we = 1'b0;
    blank = 1'b1; rom_q = 4'd3;
    tick();
    check("pal_lat1", {20'd0, red, green, blue}, 32'h000);
    tick();
    check("pal_lat2", {20'd0, red, green, blue}, 32'hF80);
    pal_we = 1'b1; pal_wdata = 12'h0AB;
    tick();
    pal_we = 1'b0;
    check("pal_same_cycle_old", {20'd0, red, green, blue}, 32'hF80);
    tick();
    check("pal_new", {20'd0, red, green, blue}, 32'h0AB);
    blank = 1'b0;
    tick();
    check("blank_lat1", {20'd0, red, green, blue}, 32'h0AB);
    tick();
    check("blank_lat2", {20'd0, red, green, blue}, 32'h000);
    blank = 1'b1;
    tick();
    tick();
    check("pal_before_reset", {20'd0, red, green, blue}, 32'h0AB);
    reset = 1'b1;
    tick();
    check("reset_rgb_mid", {20'd0, red, green, blue}, 32'h000);
    reset = 1'b0;
    tick();
    tick();
    check("pal_cleared", {20'd0, red, green, blue}, 32'h000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
